// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - handshake and result bundle between decode, execute and memory stages
interface alu_exec_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_operation;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [4:0]       rd_addr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [4:0]       out_rd_addr;
  logic             out_we;
  logic             out_zero;
  logic             out_illegal;
  logic             illegal_seen;
  logic [CNT_W-1:0] op_count;

  // Upstream/downstream side (decode source and memory-stage sink)
  modport master (
    output in_valid, alu_operation, rs1_data, rs2_data, rd_addr, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd_addr, out_we, out_zero,
    input  out_illegal, illegal_seen, op_count
  );

  // Execute stage side
  modport slave (
    input  in_valid, alu_operation, rs1_data, rs2_data, rd_addr, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd_addr, out_we, out_zero,
    output out_illegal, illegal_seen, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with EX/MEM register, retired-op counter, illegal flag
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ILL5 = 3'd5,
    OP_ILL6 = 3'd6,
    OP_DIS  = 3'd7
  } alu_op_e;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [4:0]       out_rd_addr_q, out_rd_addr_d;
  logic             out_we_q, out_we_d;
  logic             out_zero_q, out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic             illegal_seen_q, illegal_seen_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [XLEN-1:0]  alu_result;
  logic             op_legal;
  logic             op_illegal;
  logic             op_disabled;
  logic             in_ready;
  logic             accept;
  logic             handoff;

  // A new op may enter whenever the register is empty or being drained this cycle
  assign in_ready = !out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready & !bus.flush;
  assign handoff  = out_valid_q & bus.out_ready;

  // Operation decode and datapath; illegal and disabled codes yield a zero result
  always_comb begin
    alu_result  = '0;
    op_legal    = 1'b1;
    op_illegal  = 1'b0;
    op_disabled = 1'b0;
    case (alu_op_e'(bus.alu_operation))
      OP_ADD:  alu_result = bus.rs1_data + bus.rs2_data;
      OP_SUB:  alu_result = bus.rs1_data - bus.rs2_data;
      OP_AND:  alu_result = bus.rs1_data & bus.rs2_data;
      OP_OR:   alu_result = bus.rs1_data | bus.rs2_data;
      OP_XOR:  alu_result = bus.rs1_data ^ bus.rs2_data;
      OP_ILL5, OP_ILL6: begin
        op_legal   = 1'b0;
        op_illegal = 1'b1;
      end
      default: begin
        op_legal    = 1'b0;
        op_disabled = 1'b1;
      end
    endcase
  end

  // Next-state of the EX/MEM register: flush beats accept, accept beats plain drain
  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_rd_addr_d  = out_rd_addr_q;
    out_we_d       = out_we_q;
    out_zero_d     = out_zero_q;
    out_illegal_d  = out_illegal_q;
    illegal_seen_d = illegal_seen_q | (accept & op_illegal);
    op_count_d     = op_count_q;

    // A result killed by flush is never counted, even if downstream took it
    if (handoff && !bus.flush) begin
      op_count_d = op_count_q + 1'b1;
    end

    if (bus.flush) begin
      out_valid_d   = 1'b0;
      out_we_d      = 1'b0;
      out_illegal_d = 1'b0;
    end else if (accept) begin
      // Disabled ops are consumed but leave a bubble behind
      out_valid_d   = !op_disabled;
      out_result_d  = alu_result;
      out_rd_addr_d = bus.rd_addr;
      out_we_d      = op_legal & (bus.rd_addr != 5'd0);
      out_zero_d    = (alu_result == '0);
      out_illegal_d = op_illegal;
    end else if (handoff) begin
      out_valid_d   = 1'b0;
      out_we_d      = 1'b0;
      out_illegal_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_rd_addr_q  <= '0;
      out_we_q       <= 1'b0;
      out_zero_q     <= 1'b0;
      out_illegal_q  <= 1'b0;
      illegal_seen_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_rd_addr_q  <= out_rd_addr_d;
      out_we_q       <= out_we_d;
      out_zero_q     <= out_zero_d;
      out_illegal_q  <= out_illegal_d;
      illegal_seen_q <= illegal_seen_d;
      op_count_q     <= op_count_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_rd_addr  = out_rd_addr_q;
  assign bus.out_we       = out_we_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_illegal  = out_illegal_q;
  assign bus.illegal_seen = illegal_seen_q;
  assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_exec_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  alu_exec_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.alu_operation = op;
    bus.rs1_data      = a;
    bus.rs2_data      = b;
    bus.rd_addr       = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  ops  [5];
    logic [31:0] exps [5];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid      = 1'b0;
    bus.alu_operation = 3'd0;
    bus.rs1_data      = '0;
    bus.rs2_data      = '0;
    bus.rd_addr       = '0;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_we", bus.out_we, 0);
    check("rst_count", bus.op_count, 0);
    check("rst_illseen", bus.illegal_seen, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // Back-to-back ALU ops with downstream always ready
    send(3'd0, 32'd5, 32'd7, 5'd1);
    step();
    check("add_valid", bus.out_valid, 1);
    check("add_result", bus.out_result, 32'd12);
    check("add_we", bus.out_we, 1);
    check("add_rd", bus.out_rd_addr, 1);
    check("add_zero", bus.out_zero, 0);
    check("add_count", bus.op_count, 0);
    send(3'd1, 32'd3, 32'd5, 5'd2);
    step();
    check("sub_result", bus.out_result, 32'hFFFF_FFFE);
    check("sub_count", bus.op_count, 1);
    ops  = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    exps = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3);
      step();
      check($sformatf("logic%0d_result", i), bus.out_result, exps[i]);
      check($sformatf("logic%0d_count", i), bus.op_count, 64'(i + 2));
    end
    idle();
    step();
    check("b2b_count", bus.op_count, 5);
    check("b2b_drain_valid", bus.out_valid, 0);

    // Backpressure: result frozen, next op waits and loads on release edge
    bus.out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd1, 5'd3);
    step();
    check("bp_valid", bus.out_valid, 1);
    check("bp_result", bus.out_result, 2);
    send(3'd0, 32'd10, 32'd20, 5'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
      check($sformatf("bp_hold_result%0d", i), bus.out_result, 2);
      check($sformatf("bp_hold_rd%0d", i), bus.out_rd_addr, 3);
      check($sformatf("bp_hold_count%0d", i), bus.op_count, 5);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    check("bp_next_result", bus.out_result, 30);
    check("bp_next_rd", bus.out_rd_addr, 4);
    check("bp_next_count", bus.op_count, 6);
    idle();
    step();
    check("bp_drain_count", bus.op_count, 7);
    check("bp_drain_valid", bus.out_valid, 0);

    // Illegal codes 5/6 and disabled code 7
    send(3'd5, 32'd1, 32'd2, 5'd5);
    step();
    check("ill5_valid", bus.out_valid, 1);
    check("ill5_illegal", bus.out_illegal, 1);
    check("ill5_we", bus.out_we, 0);
    check("ill5_result", bus.out_result, 0);
    check("ill5_seen", bus.illegal_seen, 1);
    send(3'd6, 32'd8, 32'd9, 5'd6);
    step();
    check("ill6_illegal", bus.out_illegal, 1);
    check("ill6_we", bus.out_we, 0);
    check("ill6_count", bus.op_count, 8);
    send(3'd7, 32'd4, 32'd4, 5'd7);
    step();
    check("dis_valid", bus.out_valid, 0);
    check("dis_count", bus.op_count, 9);
    check("dis_seen", bus.illegal_seen, 1);
    idle();
    step();
    check("dis_idle_valid", bus.out_valid, 0);
    check("dis_idle_count", bus.op_count, 9);

    // Flush while holding, flush with an open slot, then rd_addr=0 write enable
    bus.out_ready = 1'b0;
    send(3'd0, 32'd2, 32'd2, 5'd7);
    step();
    check("fl_hold_valid", bus.out_valid, 1);
    send(3'd0, 32'd100, 32'd100, 5'd8);
    bus.flush = 1'b1;
    step();
    check("fl_valid", bus.out_valid, 0);
    check("fl_we", bus.out_we, 0);
    check("fl_illegal", bus.out_illegal, 0);
    check("fl_count", bus.op_count, 9);
    step();
    check("fl_open_valid", bus.out_valid, 0);
    bus.flush = 1'b0;
    idle();
    step();
    check("fl_after_valid", bus.out_valid, 0);
    check("fl_after_count", bus.op_count, 9);
    bus.out_ready = 1'b1;
    send(3'd0, 32'd3, 32'd4, 5'd0);
    step();
    check("rd0_valid", bus.out_valid, 1);
    check("rd0_we", bus.out_we, 0);
    check("rd0_result", bus.out_result, 7);
    idle();
    step();
    check("rd0_count", bus.op_count, 10);

    // Asynchronous reset mid-operation
    bus.out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd1, 5'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_count", bus.op_count, 0);
    check("arst_seen", bus.illegal_seen, 0);
    check("arst_result", bus.out_result, 0);
    check("arst_in_ready", bus.in_ready, 1);

    // Counter wrap over 17 handoffs, zero flag edge cases
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(3'd1, 32'd0, 32'd1, 5'd9);
    step();
    check("first_accept_valid", bus.out_valid, 1);
    check("sub_wrap_result", bus.out_result, 32'hFFFF_FFFF);
    check("sub_wrap_zero", bus.out_zero, 0);
    for (int i = 0; i < 15; i++) begin
      send(3'd0, 32'(i), 32'd1, 5'd10);
      step();
    end
    send(3'd1, 32'd9, 32'd9, 5'd11);
    step();
    check("sub_eq_zero", bus.out_zero, 1);
    check("sub_eq_result", bus.out_result, 0);
    check("wrap16_count", bus.op_count, 0);
    idle();
    step();
    check("wrap17_count", bus.op_count, 1);
    check("wrap_drain_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
